// File: rtl/cdb_arbiter_if.sv
// Request and broadcast signals between the ALU/LSB result producers and the
// common data bus arbiter. The master drives results in; the slave is the arbiter.
interface cdb_arbiter_if;
  // ALU result request channel
  logic        in_alu_valid;
  logic [3:0]  in_alu_reorder;
  logic [31:0] in_alu_result;
  logic [31:0] in_alu_branch;
  logic        out_alu_ready;

  // LSB result request channel
  logic        in_lsb_valid;
  logic [3:0]  in_lsb_reorder;
  logic [31:0] in_lsb_result;
  logic        in_lsb_io_read;
  logic        out_lsb_ready;

  // Registered broadcast onto the common data bus
  logic        out_cdb_enable;
  logic [3:0]  out_cdb_reorder;
  logic [31:0] out_cdb_result;
  logic [31:0] out_cdb_branch;
  logic        out_cdb_io_read;
  logic        out_cdb_src;

  modport master (
    output in_alu_valid, in_alu_reorder, in_alu_result, in_alu_branch,
    input  out_alu_ready,
    output in_lsb_valid, in_lsb_reorder, in_lsb_result, in_lsb_io_read,
    input  out_lsb_ready,
    input  out_cdb_enable, out_cdb_reorder, out_cdb_result, out_cdb_branch,
    input  out_cdb_io_read, out_cdb_src
  );

  modport slave (
    input  in_alu_valid, in_alu_reorder, in_alu_result, in_alu_branch,
    output out_alu_ready,
    input  in_lsb_valid, in_lsb_reorder, in_lsb_result, in_lsb_io_read,
    output out_lsb_ready,
    output out_cdb_enable, out_cdb_reorder, out_cdb_result, out_cdb_branch,
    output out_cdb_io_read, out_cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers ALU and LSB results in small per-source
// circular FIFOs and broadcasts one result per enabled cycle, alternating
// between sources whenever both have something pending.
module cdb_arbiter #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic         in_clk,
  input  logic         in_rst,
  input  logic         in_rdy,
  input  logic         in_flush,
  cdb_arbiter_if.slave bus
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);

  typedef enum logic { SRC_ALU = 1'b0, SRC_LSB = 1'b1 } src_e;

  typedef struct packed {
    logic [3:0]  reorder;
    logic [31:0] result;
    logic [31:0] branch;
  } alu_entry_t;

  typedef struct packed {
    logic [3:0]  reorder;
    logic [31:0] result;
    logic        io_read;
  } lsb_entry_t;

  alu_entry_t alu_mem [FIFO_DEPTH];
  lsb_entry_t lsb_mem [FIFO_DEPTH];

  logic [PW-1:0] alu_head_q, alu_head_d, alu_tail_q, alu_tail_d;
  logic [PW-1:0] lsb_head_q, lsb_head_d, lsb_tail_q, lsb_tail_d;
  logic [CW-1:0] alu_cnt_q, alu_cnt_d, lsb_cnt_q, lsb_cnt_d;
  src_e          last_grant_q, last_grant_d;

  logic          cdb_en_q, cdb_en_d;
  logic [3:0]    cdb_reorder_q, cdb_reorder_d;
  logic [31:0]   cdb_result_q, cdb_result_d;
  logic [31:0]   cdb_branch_q, cdb_branch_d;
  logic          cdb_io_q, cdb_io_d;
  src_e          cdb_src_q, cdb_src_d;

  logic alu_ready, lsb_ready, alu_push, lsb_push, alu_pop, lsb_pop;
  logic alu_ne, lsb_ne, active;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == LAST) return '0;
    return p + PW'(1);
  endfunction

  // Acceptance and grant decisions for the current cycle.
  always_comb begin
    active    = in_rdy && !in_flush;
    alu_ne    = (alu_cnt_q != '0);
    lsb_ne    = (lsb_cnt_q != '0);
    // A same-cycle pop never frees a slot, so ready looks only at the count.
    alu_ready = in_rdy && !in_rst && !in_flush && (alu_cnt_q != FULL);
    lsb_ready = in_rdy && !in_rst && !in_flush && (lsb_cnt_q != FULL);
    alu_push  = bus.in_alu_valid && alu_ready;
    lsb_push  = bus.in_lsb_valid && lsb_ready;
    alu_pop   = active && alu_ne && (!lsb_ne || last_grant_q == SRC_LSB);
    lsb_pop   = active && lsb_ne && (!alu_ne || last_grant_q == SRC_ALU);
  end

  // Next-state for pointers, counts, last grant and the broadcast registers.
  always_comb begin
    // NOTE: every _d starts from its _q so no path leaves a latch behind.
    alu_head_d    = alu_head_q;
    alu_tail_d    = alu_tail_q;
    alu_cnt_d     = alu_cnt_q;
    lsb_head_d    = lsb_head_q;
    lsb_tail_d    = lsb_tail_q;
    lsb_cnt_d     = lsb_cnt_q;
    last_grant_d  = last_grant_q;
    cdb_en_d      = cdb_en_q;
    cdb_reorder_d = cdb_reorder_q;
    cdb_result_d  = cdb_result_q;
    cdb_branch_d  = cdb_branch_q;
    cdb_io_d      = cdb_io_q;
    cdb_src_d     = cdb_src_q;

    if (in_rdy) begin
      if (in_flush) begin
        alu_head_d = '0;
        alu_tail_d = '0;
        alu_cnt_d  = '0;
        lsb_head_d = '0;
        lsb_tail_d = '0;
        lsb_cnt_d  = '0;
        cdb_en_d   = 1'b0;
      end else begin
        if (alu_push) alu_tail_d = ptr_inc(alu_tail_q);
        if (alu_pop)  alu_head_d = ptr_inc(alu_head_q);
        if (lsb_push) lsb_tail_d = ptr_inc(lsb_tail_q);
        if (lsb_pop)  lsb_head_d = ptr_inc(lsb_head_q);
        alu_cnt_d = alu_cnt_q + CW'(alu_push) - CW'(alu_pop);
        lsb_cnt_d = lsb_cnt_q + CW'(lsb_push) - CW'(lsb_pop);
        cdb_en_d  = alu_pop || lsb_pop;
        if (alu_pop) begin
          last_grant_d  = SRC_ALU;
          cdb_src_d     = SRC_ALU;
          cdb_reorder_d = alu_mem[alu_head_q].reorder;
          cdb_result_d  = alu_mem[alu_head_q].result;
          cdb_branch_d  = alu_mem[alu_head_q].branch;
          cdb_io_d      = 1'b0;
        end else if (lsb_pop) begin
          last_grant_d  = SRC_LSB;
          cdb_src_d     = SRC_LSB;
          cdb_reorder_d = lsb_mem[lsb_head_q].reorder;
          cdb_result_d  = lsb_mem[lsb_head_q].result;
          cdb_branch_d  = '0;
          cdb_io_d      = lsb_mem[lsb_head_q].io_read;
        end
      end
    end
  end

  // Control and broadcast registers with synchronous reset.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      alu_head_q    <= '0;
      alu_tail_q    <= '0;
      alu_cnt_q     <= '0;
      lsb_head_q    <= '0;
      lsb_tail_q    <= '0;
      lsb_cnt_q     <= '0;
      last_grant_q  <= SRC_LSB;
      cdb_en_q      <= 1'b0;
      cdb_reorder_q <= '0;
      cdb_result_q  <= '0;
      cdb_branch_q  <= '0;
      cdb_io_q      <= 1'b0;
      cdb_src_q     <= SRC_ALU;
    end else begin
      alu_head_q    <= alu_head_d;
      alu_tail_q    <= alu_tail_d;
      alu_cnt_q     <= alu_cnt_d;
      lsb_head_q    <= lsb_head_d;
      lsb_tail_q    <= lsb_tail_d;
      lsb_cnt_q     <= lsb_cnt_d;
      last_grant_q  <= last_grant_d;
      cdb_en_q      <= cdb_en_d;
      cdb_reorder_q <= cdb_reorder_d;
      cdb_result_q  <= cdb_result_d;
      cdb_branch_q  <= cdb_branch_d;
      cdb_io_q      <= cdb_io_d;
      cdb_src_q     <= cdb_src_d;
    end
  end

  // FIFO storage writes on accepted pushes.
  // NOTE: storage is not reset; the counts alone decide which slots are live.
  always_ff @(posedge in_clk) begin
    if (alu_push) alu_mem[alu_tail_q] <= '{bus.in_alu_reorder, bus.in_alu_result, bus.in_alu_branch};
    if (lsb_push) lsb_mem[lsb_tail_q] <= '{bus.in_lsb_reorder, bus.in_lsb_result, bus.in_lsb_io_read};
  end

  assign bus.out_alu_ready   = alu_ready;
  assign bus.out_lsb_ready   = lsb_ready;
  assign bus.out_cdb_enable  = cdb_en_q;
  assign bus.out_cdb_reorder = cdb_reorder_q;
  assign bus.out_cdb_result  = cdb_result_q;
  assign bus.out_cdb_branch  = cdb_branch_q;
  assign bus.out_cdb_io_read = cdb_io_q;
  assign bus.out_cdb_src     = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: a table of directed vectors covering
// reset, single grants, ties, full FIFOs, flush and stall, followed by a
// continuous two-source sequence checked against a scoreboard.
module tb_cdb_arbiter;

  logic in_clk = 1'b0;
  logic in_rst, in_rdy, in_flush;

  cdb_arbiter_if bus ();

  cdb_arbiter #(.FIFO_DEPTH(2)) dut (
    .in_clk   (in_clk),
    .in_rst   (in_rst),
    .in_rdy   (in_rdy),
    .in_flush (in_flush),
    .bus      (bus.slave)
  );

  always #5 in_clk = ~in_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic        rst, rdy, flush;
    logic        av;  logic [3:0] at;  logic [31:0] ar, ab;
    logic        lv;  logic [3:0] lt;  logic [31:0] lr;  logic lio;
    logic        e_ar, e_lr;
    logic        e_en; logic [3:0] e_tag; logic [31:0] e_res, e_br; logic e_io, e_src;
  } vec_t;

  function automatic vec_t v(
    input logic rst, rdy, flush,
    input logic av, input logic [3:0] at, input logic [31:0] ar, ab,
    input logic lv, input logic [3:0] lt, input logic [31:0] lr, input logic lio,
    input logic e_ar, e_lr,
    input logic e_en, input logic [3:0] e_tag, input logic [31:0] e_res, e_br,
    input logic e_io, e_src);
    vec_t r;
    r.rst = rst; r.rdy = rdy; r.flush = flush;
    r.av = av; r.at = at; r.ar = ar; r.ab = ab;
    r.lv = lv; r.lt = lt; r.lr = lr; r.lio = lio;
    r.e_ar = e_ar; r.e_lr = e_lr;
    r.e_en = e_en; r.e_tag = e_tag; r.e_res = e_res; r.e_br = e_br;
    r.e_io = e_io; r.e_src = e_src;
    return r;
  endfunction

  task automatic drive(input logic rst, rdy, flush,
                       input logic av, input logic [3:0] at, input logic [31:0] ar, ab,
                       input logic lv, input logic [3:0] lt, input logic [31:0] lr,
                       input logic lio);
    in_rst = rst; in_rdy = rdy; in_flush = flush;
    bus.in_alu_valid = av; bus.in_alu_reorder = at;
    bus.in_alu_result = ar; bus.in_alu_branch = ab;
    bus.in_lsb_valid = lv; bus.in_lsb_reorder = lt;
    bus.in_lsb_result = lr; bus.in_lsb_io_read = lio;
  endtask

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] res;
    int          cyc;
  } ent_t;

  vec_t vecs[$];
  ent_t qa[$];
  ent_t ql[$];

  initial begin
    // rst rdy fl | av at ar ab | lv lt lr lio | e_ar e_lr | en tag res br io src
    vecs.push_back(v(1,1,0, 0,0,0,0,             0,0,0,0,       0,0, 0,0,0,0,0,0));                 // 0 reset
    vecs.push_back(v(0,1,0, 1,3,'h11,'h100,      0,0,0,0,       1,1, 0,0,0,0,0,0));                 // 1 ALU push
    vecs.push_back(v(0,1,0, 0,0,0,0,             0,0,0,0,       1,1, 1,3,'h11,'h100,0,0));          // 2 broadcast
    vecs.push_back(v(0,1,0, 0,0,0,0,             0,0,0,0,       1,1, 0,3,'h11,'h100,0,0));          // 3 pulse ends, hold
    vecs.push_back(v(0,1,0, 1,6,'h66,'h600,      1,5,'hC5,0,    1,1, 0,3,'h11,'h100,0,0));          // 4 both push
    vecs.push_back(v(0,1,0, 1,7,'h77,'h700,      0,0,0,0,       1,1, 1,5,'hC5,0,0,1));              // 5 LSB wins tie
    vecs.push_back(v(0,1,0, 1,8,'h88,'h800,      0,0,0,0,       0,1, 1,6,'h66,'h600,0,0));          // 6 ALU full, drop
    vecs.push_back(v(0,1,0, 0,0,0,0,             0,0,0,0,       1,1, 1,7,'h77,'h700,0,0));          // 7 second ALU
    vecs.push_back(v(0,1,0, 0,0,0,0,             0,0,0,0,       1,1, 0,7,'h77,'h700,0,0));          // 8 dropped not seen
    vecs.push_back(v(0,1,0, 1,9,'h99,'h900,      0,0,0,0,       1,1, 0,7,'h77,'h700,0,0));          // 9 buffer one
    vecs.push_back(v(1,1,0, 1,'hA,'hAA,'hA00,    0,0,0,0,       0,0, 0,0,0,0,0,0));                 // 10 mid-op reset
    vecs.push_back(v(0,1,0, 0,0,0,0,             0,0,0,0,       1,1, 0,0,0,0,0,0));                 // 11 entry discarded
    vecs.push_back(v(0,1,0, 1,1,'hA1,'h200,      1,2,'hB2,1,    1,1, 0,0,0,0,0,0));                 // 12 both push
    vecs.push_back(v(0,1,0, 0,0,0,0,             0,0,0,0,       1,1, 1,1,'hA1,'h200,0,0));          // 13 ALU first
    vecs.push_back(v(0,1,0, 0,0,0,0,             0,0,0,0,       1,1, 1,2,'hB2,0,1,1));              // 14 then LSB
    vecs.push_back(v(0,1,0, 0,0,0,0,             0,0,0,0,       1,1, 0,2,'hB2,0,1,1));              // 15 idle
    vecs.push_back(v(0,1,0, 1,4,'h41,'h410,      1,5,'h51,0,    1,1, 0,2,'hB2,0,1,1));              // 16 fill
    vecs.push_back(v(0,1,0, 1,6,'h61,'h610,      1,7,'h71,1,    1,1, 1,4,'h41,'h410,0,0));          // 17 fill
    vecs.push_back(v(0,1,0, 1,8,'h81,'h810,      0,0,0,0,       1,0, 1,5,'h51,0,0,1));              // 18 2 ALU + 1 LSB
    vecs.push_back(v(0,1,1, 1,'hC,'hC1,'hC10,    1,'hD,'hD1,0,  0,0, 0,5,'h51,0,0,1));              // 19 flush
    vecs.push_back(v(0,1,0, 0,0,0,0,             0,0,0,0,       1,1, 0,5,'h51,0,0,1));              // 20 empty
    vecs.push_back(v(0,1,0, 0,0,0,0,             1,9,'h91,1,    1,1, 0,5,'h51,0,0,1));              // 21 new push
    vecs.push_back(v(0,1,0, 0,0,0,0,             0,0,0,0,       1,1, 1,9,'h91,0,1,1));              // 22 broadcast
    vecs.push_back(v(0,1,0, 0,0,0,0,             0,0,0,0,       1,1, 0,9,'h91,0,1,1));              // 23 idle
    vecs.push_back(v(0,1,0, 1,'hA,'hA0,'hA00,    1,'hB,'hB0,0,  1,1, 0,9,'h91,0,1,1));              // 24 both push
    vecs.push_back(v(0,1,0, 0,0,0,0,             0,0,0,0,       1,1, 1,'hA,'hA0,'hA00,0,0));        // 25 ALU grant
    vecs.push_back(v(0,0,0, 1,'hE,'hE0,'hE00,    0,0,0,0,       0,0, 1,'hA,'hA0,'hA00,0,0));        // 26 stall
    vecs.push_back(v(0,0,0, 1,'hE,'hE0,'hE00,    0,0,0,0,       0,0, 1,'hA,'hA0,'hA00,0,0));        // 27 stall
    vecs.push_back(v(0,0,0, 1,'hE,'hE0,'hE00,    0,0,0,0,       0,0, 1,'hA,'hA0,'hA00,0,0));        // 28 stall
    vecs.push_back(v(0,1,0, 0,0,0,0,             0,0,0,0,       1,1, 1,'hB,'hB0,0,0,1));            // 29 resume LSB
    vecs.push_back(v(0,1,0, 0,0,0,0,             0,0,0,0,       1,1, 0,'hB,'hB0,0,0,1));            // 30 stalled push lost

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].rdy, vecs[i].flush,
            vecs[i].av, vecs[i].at, vecs[i].ar, vecs[i].ab,
            vecs[i].lv, vecs[i].lt, vecs[i].lr, vecs[i].lio);
      #2;
      check($sformatf("v%0d alu_ready", i), 32'(bus.out_alu_ready), 32'(vecs[i].e_ar));
      check($sformatf("v%0d lsb_ready", i), 32'(bus.out_lsb_ready), 32'(vecs[i].e_lr));
      @(posedge in_clk);
      #1;
      check($sformatf("v%0d enable", i),  32'(bus.out_cdb_enable),  32'(vecs[i].e_en));
      check($sformatf("v%0d reorder", i), 32'(bus.out_cdb_reorder), 32'(vecs[i].e_tag));
      check($sformatf("v%0d result", i),  bus.out_cdb_result,       vecs[i].e_res);
      check($sformatf("v%0d branch", i),  bus.out_cdb_branch,       vecs[i].e_br);
      check($sformatf("v%0d io_read", i), 32'(bus.out_cdb_io_read), 32'(vecs[i].e_io));
      check($sformatf("v%0d src", i),     32'(bus.out_cdb_src),     32'(vecs[i].e_src));
    end

    // Continuous pushes from both sources for 10 cycles, then drain.
    drive(1,1,0, 0,0,0,0, 0,0,0,0);
    @(posedge in_clk);
    #1;
    begin
      logic       last_src = 1'b1;
      int         a_seq = 0;
      int         l_seq = 0;
      for (int c = 0; c < 16; c++) begin
        logic push_on, exp_ar, exp_lr, a_push, l_push, exp_src;
        int   na, nl;
        ent_t e;
        push_on = (c < 10);
        drive(0,1,0, push_on, 4'(a_seq), 32'h1000 + 32'(a_seq), 32'h5000 + 32'(a_seq),
              push_on, 4'(l_seq), 32'h2000 + 32'(l_seq), l_seq[0]);
        #2;
        na = qa.size();
        nl = ql.size();
        exp_ar = (na != 2);
        exp_lr = (nl != 2);
        check($sformatf("c%0d alu_ready", c), 32'(bus.out_alu_ready), 32'(exp_ar));
        check($sformatf("c%0d lsb_ready", c), 32'(bus.out_lsb_ready), 32'(exp_lr));
        a_push = push_on && exp_ar;
        l_push = push_on && exp_lr;
        @(posedge in_clk);
        #1;
        if (na > 0 || nl > 0) begin
          check($sformatf("c%0d enable", c), 32'(bus.out_cdb_enable), 32'd1);
          if (na > 0 && nl > 0) exp_src = ~last_src;
          else                  exp_src = (nl > 0);
          check($sformatf("c%0d src", c), 32'(bus.out_cdb_src), 32'(exp_src));
          if (exp_src) e = ql.pop_front();
          else         e = qa.pop_front();
          check($sformatf("c%0d reorder", c), 32'(bus.out_cdb_reorder), 32'(e.tag));
          check($sformatf("c%0d result", c),  bus.out_cdb_result,       e.res);
          check($sformatf("c%0d latency", c), 32'(c - e.cyc <= 4),      32'd1);
          last_src = exp_src;
        end else begin
          check($sformatf("c%0d enable", c), 32'(bus.out_cdb_enable), 32'd0);
        end
        if (a_push) begin
          qa.push_back('{4'(a_seq), 32'h1000 + 32'(a_seq), c});
          a_seq++;
        end
        if (l_push) begin
          ql.push_back('{4'(l_seq), 32'h2000 + 32'(l_seq), c});
          l_seq++;
        end
      end
      check("drain alu empty", 32'(qa.size()), 32'd0);
      check("drain lsb empty", 32'(ql.size()), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
